lsu: RTL

- Load/store unit for the miniRV single-cycle core. Sits directly downstream of the ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Runs one aligned transaction on a simple req/ack data bus, returning sign- or zero-extended load data for writeback.
- Stalls the core (holds PC and register-file write) until the access completes.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared funct3 and FSM state encodings for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Unsigned variants only make sense for loads.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_B, LSU_H, LSU_W: ok = 1'b1;
      LSU_BU, LSU_HU:      ok = ~we;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Byte-enable, store-lane replication and load-extract datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = bus_rdata[{addr, 3'b000} +: 8];
    w_half    = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = bus_rdata;
    misalign  = 1'b0;
    case (funct3)
      LSU_B, LSU_BU: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~funct3[2] & w_byte[7]}}, w_byte};
      end
      LSU_H, LSU_HU: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~funct3[2] & w_half[15]}}, w_half};
        misalign  = addr[0];
      end
      LSU_W: begin
        be       = 4'b1111;
        misalign = |addr;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit: one aligned req/ack bus access per instruction,
//            stalling the core until the access completes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  lsu_state_e  r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic [2:0]  w_funct3;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;
  logic        w_misalign;
  logic        w_illegal;

  // Extraction at ack time uses the lane captured at issue, not live inputs.
  assign w_funct3  = (r_state == IDLE) ? funct3_i : r_funct3;
  assign w_off     = (r_state == IDLE) ? addr_i[1:0] : r_off;
  assign w_illegal = w_misalign | ~funct3_legal(funct3_i, we_i);
  assign stall_o   = req_i & (r_state != DONE);

  lsu_align u_align (
    .funct3    (w_funct3),
    .addr      (w_off),
    .wdata     (wdata_i),
    .bus_rdata (bus_rdata_i),
    .be        (w_be),
    .wdata_rep (w_wdata_rep),
    .rdata_ext (w_rdata_ext),
    .misalign  (w_misalign)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      rdata_o     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= 4'b0000;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            if (w_illegal) begin
              r_state <= DONE;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else begin
              r_state     <= BUS;
              r_funct3    <= funct3_i;
              r_off       <= addr_i[1:0];
              bus_req_o   <= 1'b1;
              bus_we_o    <= we_i;
              bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              bus_wdata_o <= w_wdata_rep;
              bus_be_o    <= w_be;
            end
          end
        end
        BUS: begin
          if (bus_ack_i) begin
            r_state   <= DONE;
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            rdata_o   <= bus_we_o ? '0 : w_rdata_ext;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
